// File: rtl/sim_clk_pkg.sv
// Shared helpers for clock dividers: low/high split of a period and phase
// counter width.
package sim_clk_pkg;

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
    } split_t;

    // Odd periods give the spare cycle to the high phase.
    function automatic split_t phase_split(input int t);
        split_t s;
        s.lo = 32'(t / 2);
        s.hi = 32'(t - (t / 2));
        return s;
    endfunction

    function automatic int ph_width(input int t);
        return ($clog2(t) < 1) ? 1 : $clog2(t);
    endfunction

endpackage

// File: rtl/sim_clk.sv
// Free-running low-first divided clock with rise/fall strobes and a
// wrapping count of rising edges.
module sim_clk
    import sim_clk_pkg::*;
#(
    parameter int T  = 2,
    parameter int CW = 8
)
(
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          clk_o,
    output logic          rise,
    output logic          fall,
    output logic [CW-1:0] periods
);

    localparam split_t SPLIT = phase_split(T);
    localparam int     PW    = ph_width(T);

    localparam logic [PW-1:0] LO_PH   = PW'(SPLIT.lo);
    localparam logic [PW-1:0] LAST_PH = PW'(T - 1);

    if (T < 2) begin : g_bad_period
        $error("sim_clk: T must be at least 2");
    end

    logic [PW-1:0] ph;
    logic [PW-1:0] ph_next;

    always_comb begin
        ph_next = (ph == LAST_PH) ? '0 : ph + 1'b1;
    end

    // Outputs are computed from the upcoming phase so they change on the same
    // edge as the phase itself; a disabled cycle stretches the current phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph      <= '0;
            clk_o   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            periods <= '0;
        end else if (en) begin
            ph      <= ph_next;
            clk_o   <= (ph_next >= LO_PH);
            rise    <= (ph_next == LO_PH);
            fall    <= (ph_next == '0);
            periods <= periods + CW'(ph_next == LO_PH);
        end else begin
            rise    <= 1'b0;
            fall    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sim_clk.sv
// Self-checking bench for sim_clk: four instances sharing reset/enable,
// compared against a model counting enabled edges since reset.
module tb_sim_clk;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    logic       c2, r2, f2;
    logic [7:0] p2;
    logic       c8, r8, f8;
    logic [7:0] p8;
    logic       c3, r3, f3;
    logic [7:0] p3;
    logic       cw, rw, fw;
    logic [1:0] pw;

    sim_clk #(.T(2), .CW(8)) u_t2 (.clk(clk), .rst(rst), .en(en), .clk_o(c2), .rise(r2), .fall(f2), .periods(p2));
    sim_clk #(.T(8), .CW(8)) u_t8 (.clk(clk), .rst(rst), .en(en), .clk_o(c8), .rise(r8), .fall(f8), .periods(p8));
    sim_clk #(.T(3), .CW(8)) u_t3 (.clk(clk), .rst(rst), .en(en), .clk_o(c3), .rise(r3), .fall(f3), .periods(p3));
    sim_clk #(.T(2), .CW(2)) u_wr (.clk(clk), .rst(rst), .en(en), .clk_o(cw), .rise(rw), .fall(fw), .periods(pw));

    logic [10:0] obs2, obs8, obs3, obsw;
    assign obs2 = {c2, r2, f2, p2};
    assign obs8 = {c8, r8, f8, p8};
    assign obs3 = {c3, r3, f3, p3};
    assign obsw = {cw, rw, fw, 6'b0, pw};

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int k        = 0;
    bit live     = 1'b0;

    // Number of rising edges among enabled edges 1..kk: edges where kk mod t == t/2.
    function automatic int exp_periods(input int kk, input int t);
        int lo;
        lo = t / 2;
        if (kk < lo) return 0;
        return (kk - lo) / t + 1;
    endfunction

    function automatic logic [10:0] exp_vec(input int t, input int cw_w);
        logic [10:0] v;
        int          pos;
        int          per;
        pos  = k % t;
        per  = exp_periods(k, t) % (1 << cw_w);
        v    = '0;
        v[10] = (pos >= t / 2);
        v[9]  = live && (pos == t / 2);
        v[8]  = live && (pos == 0);
        v[7:0] = 8'(per);
        return v;
    endfunction

    task automatic step(input bit rst_v, input bit en_v);
        rst = rst_v;
        en  = en_v;
        @(posedge clk);
        if (rst_v) begin
            k    = 0;
            live = 1'b0;
        end else begin
            live = en_v;
            if (en_v) k = k + 1;
        end
        #1;
    endtask

    task automatic test_reset;
        logic [10:0] e;
        step(1, 0);
        step(1, 1);
        e = 11'd0;
        n_checks++;
        if (obs2 !== e) $display("[TB] FAIL reset_t2 got %h want %h", obs2, e); else n_pass++;
        n_checks++;
        if (obs8 !== e) $display("[TB] FAIL reset_t8 got %h want %h", obs8, e); else n_pass++;
        n_checks++;
        if (obs3 !== e) $display("[TB] FAIL reset_t3 got %h want %h", obs3, e); else n_pass++;
        n_checks++;
        if (obsw !== e) $display("[TB] FAIL reset_wrap got %h want %h", obsw, e); else n_pass++;
    endtask

    task automatic test_t2;
        logic [10:0] e;
        step(1, 0);
        step(1, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1);
            e = exp_vec(2, 8);
            n_checks++;
            if (obs2 !== e) $display("[TB] FAIL t2_edge%0d got %h want %h", i, obs2, e); else n_pass++;
            if (i == 1) begin
                n_checks++;
                if (c2 !== 1'b1) $display("[TB] FAIL t2_first_high got %b want 1", c2); else n_pass++;
            end
        end
    endtask

    task automatic test_t8;
        logic [10:0] e;
        step(1, 0);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1);
            e = exp_vec(8, 8);
            n_checks++;
            if (obs8 !== e) $display("[TB] FAIL t8_edge%0d got %h want %h", i, obs8, e); else n_pass++;
            if (i == 12) begin
                n_checks++;
                if (p8 !== 8'd2) $display("[TB] FAIL t8_periods_at12 got %0d want 2", p8); else n_pass++;
            end
        end
    endtask

    task automatic test_t3_odd;
        logic [10:0] e;
        step(1, 0);
        for (int i = 1; i <= 9; i++) begin
            step(0, 1);
            e = exp_vec(3, 8);
            n_checks++;
            if (obs3 !== e) $display("[TB] FAIL t3_edge%0d got %h want %h", i, obs3, e); else n_pass++;
            n_checks++;
            if (r3 !== (i % 3 == 1)) $display("[TB] FAIL t3_rise%0d got %b want %b", i, r3, (i % 3 == 1)); else n_pass++;
        end
    endtask

    task automatic test_hold;
        logic [10:0] e;
        step(1, 0);
        for (int i = 0; i < 5; i++) step(0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0);
            e = exp_vec(8, 8);
            n_checks++;
            if (obs8 !== e) $display("[TB] FAIL hold_off%0d got %h want %h", i, obs8, e); else n_pass++;
            n_checks++;
            if (c8 !== 1'b1) $display("[TB] FAIL hold_high%0d got %b want 1", i, c8); else n_pass++;
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1);
            e = exp_vec(8, 8);
            n_checks++;
            if (obs8 !== e) $display("[TB] FAIL hold_resume%0d got %h want %h", i, obs8, e); else n_pass++;
        end
    endtask

    task automatic test_mid_reset;
        logic [10:0] e;
        step(1, 0);
        for (int i = 0; i < 6; i++) step(0, 1);
        step(1, 1);
        n_checks++;
        if (obs8 !== 11'd0) $display("[TB] FAIL midreset_clear got %h want 000", obs8); else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            step(0, 1);
            e = exp_vec(8, 8);
            n_checks++;
            if (obs8 !== e) $display("[TB] FAIL midreset_edge%0d got %h want %h", i, obs8, e); else n_pass++;
        end
        n_checks++;
        if (r8 !== 1'b1) $display("[TB] FAIL midreset_rise4 got %b want 1", r8); else n_pass++;
    endtask

    task automatic test_wrap;
        logic [10:0] e;
        step(1, 0);
        for (int i = 1; i <= 10; i++) begin
            step(0, 1);
            e = exp_vec(2, 2);
            n_checks++;
            if (obsw !== e) $display("[TB] FAIL wrap_edge%0d got %h want %h", i, obsw, e); else n_pass++;
        end
        n_checks++;
        if (pw !== 2'd1) $display("[TB] FAIL wrap_final got %0d want 1", pw); else n_pass++;
    endtask

    task automatic test_random;
        logic [10:0] e;
        bit          r_v, e_v;
        step(1, 0);
        for (int i = 0; i < 400; i++) begin
            r_v = ($urandom_range(0, 29) == 0);
            e_v = ($urandom_range(0, 3) != 0);
            step(r_v, e_v);
            e = exp_vec(2, 8);
            n_checks++;
            if (obs2 !== e) $display("[TB] FAIL rand_t2_%0d got %h want %h", i, obs2, e); else n_pass++;
            e = exp_vec(8, 8);
            n_checks++;
            if (obs8 !== e) $display("[TB] FAIL rand_t8_%0d got %h want %h", i, obs8, e); else n_pass++;
            e = exp_vec(3, 8);
            n_checks++;
            if (obs3 !== e) $display("[TB] FAIL rand_t3_%0d got %h want %h", i, obs3, e); else n_pass++;
            e = exp_vec(2, 2);
            n_checks++;
            if (obsw !== e) $display("[TB] FAIL rand_wrap_%0d got %h want %h", i, obsw, e); else n_pass++;
        end
    endtask

    initial begin
        test_reset;
        test_t2;
        test_t8;
        test_t3_odd;
        test_hold;
        test_mid_reset;
        test_wrap;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sim_clk.md
# sim_clk

Parameterised clock generator that derives a free-running, low-first output clock of period `T` from the system clock. It also provides one-cycle rising and falling strobes and a wrapping period counter. It is the common clock source for block-level simulations: the default instance provides the fast clock, and `T=8` instances provide the slow clock. It can also be used as a synthesizable divided-clock/strobe generator.

## Interface
Parameters:
- `T`, default 2: output period in `clk` cycles; must be ≥ 2, otherwise elaboration fails.
- `CW`, default 8: width of the period counter `periods`.

Ports:
- `clk` input, 1 bit: reference clock; all logic is on its rising edge.
- `rst` input, 1 bit: reset; one clock, reset is synchronous and active-high.
- `en` input, 1 bit: run enable; 0 freezes the generator.
- `clk_o` output, 1 bit: generated clock, registered.
- `rise` output, 1 bit: one-cycle strobe, high in the cycle `clk_o` first reads 1 in a period.
- `fall` output, 1 bit: one-cycle strobe, high in the cycle `clk_o` first reads 0 after being high.
- `periods` output, `CW` bits: count of rising edges of `clk_o` since reset, wrapping.

## Operation
- Constants:
  - `LO = T/2`, using integer floor.
  - `HI = T - LO`.
  - Phase counter `ph` has width `max(1, $clog2(T))` and ranges over 0..T-1.
- Reset (`rst=1` at a `clk` edge): `ph=0`, `clk_o=0`, `rise=0`, `fall=0`, `periods=0`. Reset has priority over `en`.
- Run (`rst=0`, `en=1`), per edge:
  - `n = (ph==T-1) ? 0 : ph+1`, then `ph <= n`.
  - `clk_o <= (n >= LO)`.
  - `rise <= (n == LO)`.
  - `fall <= (n == 0)`.
  - `periods <= periods + (n == LO)`, modulo 2^CW.
- Hold (`rst=0`, `en=0`):
  - `ph`, `clk_o` and `periods` keep their values.
  - `rise` and `fall` are forced to 0.
- Duty cycle:
  - Low for `LO` cycles, high for `HI` cycles.
  - For odd `T`, the extra cycle goes to the high phase.
- `rise`/`fall` are asserted in the same cycle as the corresponding `clk_o` change, never overlap, and are never asserted in the cycle after reset.

## Timing
- All outputs are registered, with zero combinational paths from inputs to outputs.
- First `clk_o` rising transition: at the `LO`-th enabled edge after reset release.
- Steady state: exactly one `rise` and one `fall` per `T` enabled cycles.
- Reset mid-period: the generator restarts at phase 0 with `clk_o` low on the next edge, and the full low phase `LO` follows.
- Deasserting `en` stretches the current phase by the number of disabled cycles. Re-enabling resumes from the held phase.
- `periods` wraps from 2^CW−1 to 0 with no flag.

## Structure
- Single module `sim_clk`; no sub-modules needed.
- A shared package `sim_clk_pkg` holds:
  - a function computing `LO`/`HI` from `T`;
  - the phase-width function `max(1, $clog2(T))`, reused by other divider blocks.
- Parameter legality check (`T<2`) is done with an elaboration-time assertion in the module.

## Test plan
- `T=2`, reset 2 cycles then `en=1`:
  - `clk_o` = 1,0,1,0… from the first edge;
  - `rise` in every cycle where `clk_o`=1, `fall` in every cycle where it is 0;
  - `periods` increments every 2 cycles.
- `T=8`:
  - `clk_o` = 0 for edges 1–3, 1 for edges 4–7, 0 for edges 8–11, and so on;
  - `rise` at edges 4, 12; `fall` at edge 8;
  - `periods`=2 after edge 12.
- `T=3` (odd): `clk_o` pattern 1,1,0 repeating from edge 1 (low 1, high 2); `rise` at edges 1, 4, 7.
- `en` low for 5 cycles mid-high-phase with `T=8`:
  - `clk_o` stays 1, `rise`/`fall` stay 0, `periods` frozen;
  - after re-enable the high phase completes its remaining cycles.
- `rst` asserted at phase 6 with `T=8`:
  - next edge gives `clk_o`=0, `periods`=0, strobes 0;
  - after release the first rise comes at the 4th edge.
- `CW=2`, `T=2`, 10 cycles: `periods` sequence 1,2,3,0,1 on successive rises.
